dc_sweep_sequencer: RTL and testbench
=====================================

Name: dc_sweep_sequencer

Overview:
- Sequences a DC operating-point sweep on a bench source/load datapath: a programmable source drives a resistive/RC load, and the load node is sampled.
- Steps the source DAC code from start to stop, waits a programmable settle time per point, requests one ADC conversion, and emits (code, sample) results over a valid/ready stream.
- Sits between the register block (sweep config, start) and the source DAC / load-node ADC interfaces.

Parameters:
- DAC_W, 12, source DAC code width
- ADC_W, 12, load-node ADC sample width
- SETTLE_W, 16, settle counter width in cycles

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a sweep when idle, ignored when busy
- abort  in  1  level; ends the sweep at the next state boundary
- v_start  in  DAC_W  first code
- v_stop  in  DAC_W  last code, inclusive
- v_step  in  DAC_W  increment; 0 means single point
- settle_cycles  in  SETTLE_W  wait after DAC accept; 0 means no wait
- dac_code  out  DAC_W  code presented to the DAC
- dac_valid  out  1  DAC write request
- dac_ready  in  1  DAC accepts when valid&ready
- adc_req  out  1  conversion request, held until ack
- adc_ack  in  1  conversion complete; adc_data valid this cycle
- adc_data  in  ADC_W  sample
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_code  out  DAC_W  code for this result
- res_data  out  ADC_W  sample for this result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at sweep end, including abort
- aborted  out  1  sticky; set on abort, cleared by next accepted start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal code and settle counter 0.
- start in IDLE latches v_start, v_stop, v_step, settle_cycles. Config changes mid-sweep have no effect.
- States and transitions:
  - IDLE -> SET on start. dac_code = current code.
  - SET: dac_valid=1 until the dac_valid&dac_ready cycle, then -> SETTLE with counter loaded from settle_cycles.
  - SETTLE: decrement the counter each cycle; at 0 -> SAMPLE. With settle_cycles=0, go to SAMPLE the cycle after the accept.
  - SAMPLE: adc_req=1. On adc_ack, capture adc_data into res_data and the current code into res_code, deassert adc_req, -> EMIT.
  - EMIT: res_valid=1. res_code and res_data are stable until res_valid&res_ready. On handshake -> STEP.
  - STEP: next = current + v_step computed at DAC_W+1 bits. If v_step==0, or carry set, or next>v_stop -> DONE; else current=next -> SET.
  - DONE: done=1 for one cycle -> IDLE.
- Latency: start to first dac_valid is 1 cycle. Per point, minimum 5 cycles plus settle plus handshake stalls.
- If v_start > v_stop, exactly one point (v_start) is measured.
- The v_stop point is included when reachable exactly. Overflow past all-ones ends the sweep, with no wrap.
- Abort handling:
  - In SET, SETTLE or STEP: -> DONE next cycle.
  - In SAMPLE: wait for adc_ack, discard the sample, then -> DONE. The ADC protocol is never broken.
  - In EMIT: complete the res handshake first, then -> DONE.
  - Sets aborted.
- start while busy is ignored, with no queuing.
- Asynchronous reset mid-sweep returns to IDLE immediately, with all requests deasserted.

Optional Feature:
- SWEEP_AVG_EN:
  - Adds parameter AVG_LOG2 (default 2).
  - SAMPLE repeats 2^AVG_LOG2 conversions per point and accumulates them in ADC_W+AVG_LOG2 bits.
  - res_data is the accumulated sum shifted right by AVG_LOG2 (truncating).
  - Abort during averaging finishes the current conversion, then -> DONE with no result.
  - Without the macro: one conversion per point, with no accumulator logic present.

Decomposition:
- Package dc_sweep_pkg holds the state enum (IDLE, SET, SETTLE, SAMPLE, EMIT, STEP, DONE) and the default width constants.
- Sub-module sweep_settle_timer: load/decrement/zero-flag counter, SETTLE_W wide.
- Everything else stays in the top-level FSM.

Test Plan:
- Sweep start=0x100, stop=0x104, step=2, settle=3, ready tied high, ADC ack after 2 cycles returning code+5 -> three results (0x100,0x105), (0x102,0x107), (0x104,0x109); then done pulse; busy low.
- v_start=0x200 > v_stop=0x100, step=1 -> exactly one result, code 0x200, then done.
- start=0xFFE, stop=0xFFF, step=4 -> one result at 0xFFE; carry ends the sweep with no wrap to 0x002.
- res_ready held low 10 cycles in EMIT -> res_code and res_data stable, no new dac_valid; after ready, the next point proceeds.
- abort asserted during SAMPLE with ADC ack delayed 6 cycles -> adc_req held until ack, no res_valid, done pulse, aborted=1; next start clears aborted.
- Reset asserted mid-SETTLE -> dac_valid, adc_req, res_valid, busy all 0 immediately; a new start runs normally from v_start.

Source files
------------

// File: rtl/dc_sweep_pkg.sv
// dc_sweep_pkg: shared state encoding and default widths for the DC sweep
// sequencer. The optional averaging feature is enabled with SWEEP_AVG_EN.
package dc_sweep_pkg;

    localparam int DAC_W_DEF    = 12;
    localparam int ADC_W_DEF    = 12;
    localparam int SETTLE_W_DEF = 16;
    localparam int AVG_LOG2_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        SAMPLE,
        EMIT,
        STEP,
        DONE
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter with a terminal-count flag.
// The counter holds at zero; the zero flag is what the sequencer keys off.
module sweep_settle_timer
    import dc_sweep_pkg::*;
#(
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_q;

    // Load takes priority over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer: steps a source DAC code from start to stop, settles,
// takes one ADC conversion per point and streams (code, sample) results.
// Optional feature macro: SWEEP_AVG_EN (averages 2^AVG_LOG2 conversions).
//
// state  | meaning
// IDLE   | waiting for start, config not latched
// SET    | presenting dac_code, waiting for dac_ready
// SETTLE | settle timer counting down to zero
// SAMPLE | adc_req held until adc_ack
// EMIT   | result held on the stream until res_ready
// STEP   | compute next code, decide continue or finish
// DONE   | one-cycle done pulse
module dc_sweep_sequencer
    import dc_sweep_pkg::*;
#(
    parameter int DAC_W    = DAC_W_DEF,
    parameter int ADC_W    = ADC_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
`ifdef SWEEP_AVG_EN
    , parameter int AVG_LOG2 = AVG_LOG2_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DAC_W-1:0]    v_start,
    input  logic [DAC_W-1:0]    v_stop,
    input  logic [DAC_W-1:0]    v_step,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [DAC_W-1:0]    dac_code,
    output logic                dac_valid,
    input  logic                dac_ready,
    output logic                adc_req,
    input  logic                adc_ack,
    input  logic [ADC_W-1:0]    adc_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DAC_W-1:0]    res_code,
    output logic [ADC_W-1:0]    res_data,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    sweep_state_e state_q, state_d;

    logic [DAC_W-1:0]    code_q;
    logic [DAC_W-1:0]    stop_q;
    logic [DAC_W-1:0]    step_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [DAC_W-1:0]    res_code_q;
    logic [ADC_W-1:0]    res_data_q;
    logic                aborted_q;

    logic [DAC_W:0]      next_code;
    logic                abort_any;
    logic                start_ok;
    logic                dac_fire;
    logic                timer_zero;
    logic                last_conv;
    logic [ADC_W-1:0]    sample_val;

    assign start_ok  = (state_q == IDLE) && start;
    assign dac_fire  = (state_q == SET) && dac_ready;
    // abort is a level but may drop before SAMPLE/EMIT finishes, so the
    // sticky flag keeps the request alive until the next state boundary.
    assign abort_any = abort | aborted_q;
    // One extra bit so a step past all-ones shows up as a carry, not a wrap.
    assign next_code = {1'b0, code_q} + {1'b0, step_q};

    sweep_settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dac_fire),
        .load_val (settle_q),
        .dec      (state_q == SETTLE),
        .zero     (timer_zero)
    );

`ifdef SWEEP_AVG_EN
    localparam int ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] conv_cnt_q;

    assign acc_sum    = acc_q + ACC_W'(adc_data);
    assign last_conv  = &conv_cnt_q;
    assign sample_val = ADC_W'(acc_sum >> AVG_LOG2);

    // Accumulate conversions for the current point; cleared outside SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            conv_cnt_q <= '0;
        end else if (state_q != SAMPLE) begin
            acc_q      <= '0;
            conv_cnt_q <= '0;
        end else if (adc_ack) begin
            acc_q      <= acc_sum;
            conv_cnt_q <= conv_cnt_q + 1'b1;
        end
    end
`else
    assign last_conv  = 1'b1;
    assign sample_val = adc_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SET;
            end
            SET: begin
                if (abort_any)      state_d = DONE;
                else if (dac_ready) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort_any)       state_d = DONE;
                else if (timer_zero) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (adc_ack) begin
                    if (abort_any)      state_d = DONE;
                    else if (last_conv) state_d = EMIT;
                end
            end
            EMIT: begin
                if (res_ready) state_d = abort_any ? DONE : STEP;
            end
            STEP: begin
                if (abort_any || (step_q == '0) || next_code[DAC_W] ||
                    (next_code[DAC_W-1:0] > stop_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = SET;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch sweep config on an accepted start and advance the code per point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            settle_q <= '0;
        end else if (start_ok) begin
            code_q   <= v_start;
            stop_q   <= v_stop;
            step_q   <= v_step;
            settle_q <= settle_cycles;
        end else if ((state_q == STEP) && (state_d == SET)) begin
            code_q   <= next_code[DAC_W-1:0];
        end
    end

    // Capture the result on the final conversion of a non-aborted point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_code_q <= '0;
            res_data_q <= '0;
        end else if ((state_q == SAMPLE) && adc_ack && last_conv && !abort_any) begin
            res_code_q <= code_q;
            res_data_q <= sample_val;
        end
    end

    // Sticky abort flag: set by abort while sweeping, cleared by next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else if (start_ok) begin
            aborted_q <= 1'b0;
        end else if (abort && (state_q != IDLE) && (state_q != DONE)) begin
            aborted_q <= 1'b1;
        end
    end

    assign dac_code  = code_q;
    assign dac_valid = (state_q == SET);
    assign adc_req   = (state_q == SAMPLE);
    assign res_valid = (state_q == EMIT);
    assign res_code  = res_code_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// tb_dc_sweep_sequencer: directed scenarios for the DC sweep sequencer with
// a simple ADC responder (ack after ack_delay request cycles, data = code+5).
module tb_dc_sweep_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] v_start;
    logic [11:0] v_stop;
    logic [11:0] v_step;
    logic [15:0] settle_cycles;
    logic [11:0] dac_code;
    logic        dac_valid;
    logic        dac_ready;
    logic        adc_req;
    logic        adc_ack;
    logic [11:0] adc_data;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_code;
    logic [11:0] res_data;
    logic        busy;
    logic        done;
    logic        aborted;

    int checks = 0;
    int errors = 0;
    int ack_delay = 2;
    int req_cnt = 0;
    int done_cnt = 0;
    int dac_cnt = 0;
    logic [11:0] rq_code[$];
    logic [11:0] rq_data[$];

    dc_sweep_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .v_start       (v_start),
        .v_stop        (v_stop),
        .v_step        (v_step),
        .settle_cycles (settle_cycles),
        .dac_code      (dac_code),
        .dac_valid     (dac_valid),
        .dac_ready     (dac_ready),
        .adc_req       (adc_req),
        .adc_ack       (adc_ack),
        .adc_data      (adc_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_code      (res_code),
        .res_data      (res_data),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC responder: counts request cycles, acks when the count hits ack_delay.
    always @(posedge clk) begin
        if (!adc_req)      req_cnt <= 0;
        else if (!adc_ack) req_cnt <= req_cnt + 1;
    end
    assign adc_ack  = adc_req && (req_cnt == ack_delay);
    assign adc_data = dac_code + 12'd5;

    // Collector: result handshakes, done pulses and DAC accepts.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            rq_code.push_back(res_code);
            rq_data.push_back(res_data);
        end
        if (done) done_cnt++;
        if (dac_valid && dac_ready) dac_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic do_start(input logic [11:0] s, input logic [11:0] e,
                            input logic [11:0] st, input logic [15:0] se);
        @(negedge clk);
        v_start = s;
        v_stop = e;
        v_step = st;
        settle_cycles = se;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done within %0d cycles, required done", name, budget);
        end
    endtask

    task automatic check_result(input string name, input int idx,
                                input logic [11:0] ec, input logic [11:0] ed);
        checks++;
        if (rq_code.size() <= idx) begin
            errors++;
            $display("FAIL %s_missing: got %0d results, required index %0d", name, rq_code.size(), idx);
        end else if (rq_code[idx] !== ec || rq_data[idx] !== ed) begin
            errors++;
            $display("FAIL %s: got (%h,%h) required (%h,%h)", name, rq_code[idx], rq_data[idx], ec, ed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        v_start = '0;
        v_stop = '0;
        v_step = '0;
        settle_cycles = '0;
        dac_ready = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dac_valid, adc_req, res_valid, busy, done, aborted} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {dac_valid, adc_req, res_valid, busy, done, aborted});
        end
        checks++;
        if ({dac_code, res_code, res_data} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {dac_code, res_code, res_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sweep();
        int d0;
        rq_code.delete();
        rq_data.delete();
        ack_delay = 2;
        d0 = done_cnt;
        do_start(12'h100, 12'h104, 12'd2, 16'd3);
        checks++;
        if (dac_valid !== 1'b1 || dac_code !== 12'h100) begin
            errors++;
            $display("FAIL basic_latency: got valid=%b code=%h required valid=1 code=100", dac_valid, dac_code);
        end
        // Config is latched; changing it now must not affect the sweep.
        v_start = 12'h000;
        v_stop = 12'h000;
        v_step = 12'd7;
        wait_done("basic", 300);
        @(negedge clk);
        checks++;
        if (rq_code.size() != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d results required 3", rq_code.size());
        end
        check_result("basic_r0", 0, 12'h100, 12'h105);
        check_result("basic_r1", 1, 12'h102, 12'h107);
        check_result("basic_r2", 2, 12'h104, 12'h109);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || (done_cnt - d0) != 1) begin
            errors++;
            $display("FAIL basic_end: got busy=%b done=%b pulses=%0d required 0 0 1", busy, done, done_cnt - d0);
        end
    endtask

    task automatic test_reverse();
        rq_code.delete();
        rq_data.delete();
        do_start(12'h200, 12'h100, 12'd1, 16'd1);
        wait_done("reverse", 200);
        @(negedge clk);
        checks++;
        if (rq_code.size() != 1) begin
            errors++;
            $display("FAIL reverse_count: got %0d results required 1", rq_code.size());
        end
        check_result("reverse_r0", 0, 12'h200, 12'h205);
    endtask

    task automatic test_overflow();
        int a0;
        rq_code.delete();
        rq_data.delete();
        a0 = dac_cnt;
        do_start(12'hFFE, 12'hFFF, 12'd4, 16'd0);
        wait_done("overflow", 200);
        @(negedge clk);
        checks++;
        if (rq_code.size() != 1 || (dac_cnt - a0) != 1) begin
            errors++;
            $display("FAIL overflow_count: got %0d results %0d dac writes required 1 1",
                     rq_code.size(), dac_cnt - a0);
        end
        check_result("overflow_r0", 0, 12'hFFE, 12'h003);
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        int unstable = 0;
        int dac_during = 0;
        int a0;
        rq_code.delete();
        rq_data.delete();
        res_ready = 1'b0;
        a0 = dac_cnt;
        do_start(12'h010, 12'h011, 12'd1, 16'd0);
        for (int i = 0; i < 50; i++) begin
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || res_code !== 12'h010 || res_data !== 12'h015) begin
            errors++;
            $display("FAIL bp_first: got seen=%b (%h,%h) required 1 (010,015)", seen, res_code, res_data);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_code !== 12'h010 || res_data !== 12'h015) unstable++;
            if (dac_valid) dac_during++;
        end
        checks++;
        if (unstable != 0 || dac_during != 0) begin
            errors++;
            $display("FAIL bp_stall: got %0d unstable %0d dac_valid cycles required 0 0", unstable, dac_during);
        end
        res_ready = 1'b1;
        wait_done("bp", 200);
        @(negedge clk);
        checks++;
        if (rq_code.size() != 2 || (dac_cnt - a0) != 2) begin
            errors++;
            $display("FAIL bp_count: got %0d results %0d dac writes required 2 2", rq_code.size(), dac_cnt - a0);
        end
        check_result("bp_r1", 1, 12'h011, 12'h016);
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        bit rv = 1'b0;
        bit dseen = 1'b0;
        int req_cycles = 0;
        rq_code.delete();
        rq_data.delete();
        ack_delay = 6;
        do_start(12'h300, 12'h3FF, 12'd1, 16'd1);
        for (int i = 0; i < 50; i++) begin
            if (adc_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        abort = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (adc_req) req_cycles++;
            if (res_valid) rv = 1'b1;
            if (done) dseen = 1'b1;
            if (i == 2) abort = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!seen || req_cycles != 7) begin
            errors++;
            $display("FAIL abort_req_hold: got seen=%b req_cycles=%0d required 1 7", seen, req_cycles);
        end
        checks++;
        if (rv || !dseen || rq_code.size() != 0) begin
            errors++;
            $display("FAIL abort_result: got res_valid=%b done=%b results=%0d required 0 1 0", rv, dseen, rq_code.size());
        end
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_flag: got aborted=%b busy=%b required 1 0", aborted, busy);
        end
        ack_delay = 2;
        do_start(12'h050, 12'h050, 12'd0, 16'd0);
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got aborted=%b required 0", aborted);
        end
        wait_done("abort_restart", 200);
        @(negedge clk);
        check_result("abort_restart_r0", 0, 12'h050, 12'h055);
    endtask

    task automatic test_reset_mid();
        rq_code.delete();
        rq_data.delete();
        do_start(12'h080, 12'h090, 12'd1, 16'd20);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dac_valid !== 1'b0 || adc_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_settle: got busy=%b dac_valid=%b adc_req=%b required 1 0 0", busy, dac_valid, adc_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dac_valid, adc_req, res_valid, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b required 00000", {dac_valid, adc_req, res_valid, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(12'h020, 12'h020, 12'd0, 16'd0);
        checks++;
        if (dac_valid !== 1'b1 || dac_code !== 12'h020) begin
            errors++;
            $display("FAIL rstmid_restart: got valid=%b code=%h required 1 020", dac_valid, dac_code);
        end
        wait_done("rstmid", 200);
        @(negedge clk);
        checks++;
        if (rq_code.size() != 1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d results required 1", rq_code.size());
        end
        check_result("rstmid_r0", 0, 12'h020, 12'h025);
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_reverse();
        test_overflow();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
